aes_sbox_serial: RTL
====================

AES_SBOX_SERIAL -- requirements
Module: aes_sbox_serial

Interface
REQ-001 Parameter LANES, default 4: number of bytes substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  producer asserts when in_data holds a 128-bit AES state.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 in_data  input  128  AES state; byte i occupies bits [127-8i:120-8i], i = 0..15.
REQ-007 out_valid  output  1  out_data holds a completed SubBytes result.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  128  forward SubBytes of the accepted in_data, same byte ordering.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Each byte SHALL map through the FIPS-197 forward S-box: high nibble selects the row, low nibble selects the column; it is the exact inverse of the team's decryption inverse S-box table.
REQ-012 The block SHALL contain exactly LANES S-box lookup instances, shared across chunks over time.
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on in_valid=1, capture in_data into the state register, clear the chunk counter, go to RUN; otherwise hold.
REQ-016 RUN: each cycle replace bytes [c*LANES .. c*LANES+LANES-1] of the state register with their S-box values, where c is the chunk counter; then increment c.
REQ-017 RUN exits to DONE on the cycle that processes chunk 16/LANES-1; the counter is log2(16/LANES) bits wide (one bit minimum) and wraps to 0 there.
REQ-018 Latency: out_valid SHALL rise exactly 16/LANES clocks after the accepting edge. For LANES=16 this is 1 clock.
REQ-019 DONE: out_valid=1 and out_data equals the state register. On out_ready=1, go to IDLE; otherwise hold out_data stable with out_valid=1.
REQ-020 out_data is the state register in every state. It is don't-care outside DONE but SHALL remain deterministic.
REQ-021 in_valid in DONE, including simultaneously with out_ready, SHALL NOT be accepted. Acceptance happens only in a later IDLE cycle, so peak throughput is one state per 16/LANES+2 clocks.
REQ-022 in_valid and in_data SHALL be ignored in RUN; a change to in_data after acceptance SHALL NOT affect the result.
REQ-023 out_ready outside DONE SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, chunk counter 0, state register 0, in_ready=1, out_valid=0, busy=0, regardless of clk.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation with no output. The first operation after rst_n rises SHALL behave as from power-up.

Verification
REQ-026 LANES=4, in_data=00112233445566778899aabbccddeeff, out_ready=1 -> out_valid 4 clocks after accept, out_data=638293c31bfc33f5c4eeacea4bc12816, then IDLE.
REQ-027 in_data all 0x00 -> out_data all 0x63. In a separate run, in_data all 0x52 -> out_data all 0x00, confirming the inverse relation with the decryption table.
REQ-028 Backpressure: hold out_ready=0 for 10 clocks in DONE -> out_valid stays 1, out_data stable, in_ready stays 0. Raise out_ready -> one handshake, then in_ready=1 on the next cycle.
REQ-029 Reset mid-RUN: assert rst_n=0 after 2 RUN clocks -> outputs take reset values immediately. The next op with in_data=0x53 repeated gives 0xED repeated.
REQ-030 Sweep LANES in {1, 2, 4, 8, 16}, run all 256 byte values (16 vectors of 16 distinct bytes) against a software S-box -> all match. Measured latency equals 16/LANES clocks.

Source files
------------

// File: rtl/aes_sbox_serial.sv
// Forward AES SubBytes over a 128-bit state, LANES bytes per clock.
// A fixed bank of LANES S-box lookups is time-shared across 16/LANES chunks.

module aes_sbox_lut (
    input  logic [7:0] a,
    output logic [7:0] q
);
    // FIPS-197 forward S-box, row = high nibble, column = low nibble
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign q = SBOX[a];
endmodule

module aes_sbox_serial #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int unsigned NCHUNK = 16 / LANES;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [127:0]        data_q, data_d;
    logic [127:0]        sub_data;
    logic [8*LANES-1:0]  lane_word;
    logic [7:0]          lane_in  [LANES];
    logic [7:0]          lane_out [LANES];

    // Select the chunk currently addressed by the counter
    if (NCHUNK == 1) begin : g_single
        assign lane_word = data_q;
    end else begin : g_multi
        logic [8*LANES-1:0] chunk [NCHUNK];
        for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
            assign chunk[c] = data_q[127-8*LANES*c -: 8*LANES];
        end
        assign lane_word = chunk[cnt_q];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = lane_word[8*LANES-1-8*l -: 8];
        aes_sbox_lut u_lut (
            .a (lane_in[l]),
            .q (lane_out[l])
        );
    end

    // State with the current chunk's bytes replaced by their substitutions
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int unsigned C = i / LANES;
        localparam int unsigned L = i % LANES;
        assign sub_data[127-8*i -: 8] = (cnt_q == CW'(C)) ? lane_out[L] : data_q[127-8*i -: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d = sub_data;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track state_q exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    assign out_data = data_q;
endmodule
